// File: rtl/reg_file_32x32_pkg.sv
// Register file shared types: sizes, address type and write decode.
// Imported by the register file top and its storage cells.
package reg_file_pkg;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // One-hot write select, qualified by we.
  // An unknown we fails the if and yields all zeros.
  function automatic logic [REG_COUNT-1:0] wr_decode(
    input logic      we,
    input reg_addr_t wa
  );
    logic [REG_COUNT-1:0] d;
    d = '0;
    if (we) d[wa] = 1'b1;
    d[ZERO_REG] = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/reg_file_32x32_reg_en_w.sv
// One WIDTH-bit storage register: load enable, async active-low clear.
// Ports: clk, rst_n, en (load), d (data in), q (stored value).
module reg_en_w #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two combinational reads, one synchronous write.
// Ports: clk, rst_n, we/wa/wd (write), ra1/rd1 and ra2/rd2 (reads).
module reg_file_32x32
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2
);

  logic [REG_COUNT-1:0] wen;
  logic [WIDTH-1:0]     regs [REG_COUNT];

  assign wen = wr_decode(we, wa);

  // r0 has no storage.
  assign regs[0] = '0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    reg_en_w #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (wen[i]),
      .d    (wd),
      .q    (regs[i])
    );
  end

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == ZERO_REG) begin
      rd1 = '0;
    end else if (BYPASS != 0 && we && ra1 == wa) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == ZERO_REG) begin
      rd2 = '0;
    end else if (BYPASS != 0 && we && ra2 == wa) begin
      rd2 = wd;
    end
  end

endmodule
